io_input_cond: RTL and testbench
================================

IO_INPUT_COND -- requirements
Module: io_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 200000, is the number of consecutive cycles a synchronized input must differ from its debounced value before the debounced value is updated (20 ms at 10 MHz); legal range is 2 or more.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth per input bit; legal range is 2 or more.
REQ-003 i_clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 i_reset  input  1  reset, synchronous and active-high.
REQ-005 i_sw  input  10  raw slide switches, asynchronous, 1 = ON.
REQ-006 i_key_n  input  4  raw push buttons, asynchronous, active-low (0 = pressed).
REQ-007 i_ack  input  4  per-key clear for the latched-press bits, one-cycle strobe.
REQ-008 o_key_press  output  4  one-cycle pulse per key on a debounced released-to-pressed transition.
REQ-009 o_io_sw  output  32  core IO word, driven from registers only: [9:0] debounced SW, [13:10] debounced key-pressed (active-high), [17:14] latched presses, [31:18] zero.

Function
REQ-010 Each of the 14 input bits SHALL pass through its own SYNC_STAGES-flop synchronizer; the last stage is the synchronized value s.
REQ-011 Each bit SHALL hold a debounced value d and a counter of width $clog2(DEBOUNCE_CYCLES) bits.
REQ-012 Per cycle, when s == d, the counter SHALL be reset to 0.
REQ-013 Per cycle, when s != d and the counter is below DEBOUNCE_CYCLES-1, the counter SHALL increment by 1.
REQ-014 Per cycle, when s != d and the counter equals DEBOUNCE_CYCLES-1, d SHALL load s and the counter SHALL return to 0; the counter SHALL never wrap.
REQ-015 Latency: an input change held steady SHALL appear on o_io_sw at rising edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new value as edge 1.
REQ-016 Any glitch that returns s to d before the count completes SHALL leave d unchanged and restart the count from 0.
REQ-017 Key bits SHALL be inverted before debouncing, so that pressed = 1 internally.
REQ-018 o_key_press[k] SHALL be 1 for exactly the cycle after debounced key k changes from 0 to 1; a debounced release SHALL produce no pulse.
REQ-019 The latched bit latch[k] SHALL be set by o_key_press[k] and cleared by i_ack[k].
REQ-020 When o_key_press[k] and i_ack[k] occur in the same cycle, set SHALL win and latch[k] SHALL remain 1.
REQ-021 i_ack on a bit that is already clear SHALL have no effect.
REQ-022 All bits SHALL operate independently; simultaneous changes on several bits SHALL each meet REQ-015.

Reset
REQ-023 While i_reset = 1 at a rising edge, all synchronizer flops and d values SHALL load the inactive level: 0 for SW, released for keys (0 internally).
REQ-024 While i_reset = 1 at a rising edge, all counters SHALL load 0.
REQ-025 While i_reset = 1 at a rising edge, the latch bits and o_key_press SHALL load 0, so o_io_sw = 0.
REQ-026 Reset asserted mid-count SHALL abandon the count.
REQ-027 A key held pressed through reset deassertion SHALL produce a press pulse after the REQ-015 latency.

Structure
REQ-028 The shared IO package SHALL hold the o_io_sw field offsets (SW_LSB=0, KEY_LSB=10, LATCH_LSB=14), the widths NUM_SW=10 and NUM_KEY=4, and the default DEBOUNCE_CYCLES.
REQ-029 A single sub-module, debounce_bit, SHALL implement the synchronizer, counter and d for one bit, instantiated 14 times in a generate loop.
REQ-030 Edge detection and latching SHALL reside in io_input_cond.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-031 Hold i_sw[0] 0->1 -> o_io_sw[0] rises exactly at edge 6 and not at edge 5.
REQ-032 Toggle i_sw[3] 1,0,1 with 2 cycles per level, then hold at 1 -> no output change during the bouncing, and o_io_sw[3]=1 six edges after the final level starts.
REQ-033 Hold i_key_n[1] low -> o_io_sw[11]=1 with one o_key_press[1] pulse, then o_io_sw[15]=1; release -> o_io_sw[11]=0 while o_io_sw[15] stays 1 and no pulse is generated.
REQ-034 Pulse i_ack[1] in the same cycle as a new o_key_press[1] -> o_io_sw[15] stays 1; i_ack[1] alone on a later cycle -> o_io_sw[15]=0.
REQ-035 Assert i_reset with i_sw=10'h3FF settled and count in progress -> o_io_sw=0 on the next edge; after deassertion, o_io_sw[9:0]=10'h3FF six edges later.

Source files
------------

// File: rtl/io_input_cond_pkg.sv
// Shared definitions for the board IO input conditioner: field layout of the
// core IO word, input widths and the default debounce interval.
package io_input_cond_pkg;

  localparam int NUM_SW   = 10;
  localparam int NUM_KEY  = 4;
  localparam int NUM_IN   = NUM_SW + NUM_KEY;
  localparam int IO_W     = 32;

  localparam int SW_LSB    = 0;
  localparam int KEY_LSB   = 10;
  localparam int LATCH_LSB = 14;

  // 20 ms at a 10 MHz core clock
  localparam int DEBOUNCE_CYCLES_DEFAULT = 200000;

  function automatic logic [IO_W-1:0] pack_io(
    input logic [NUM_SW-1:0]  sw,
    input logic [NUM_KEY-1:0] key,
    input logic [NUM_KEY-1:0] latch
  );
    logic [IO_W-1:0] w;
    w = '0;
    w[SW_LSB    +: NUM_SW]  = sw;
    w[KEY_LSB   +: NUM_KEY] = key;
    w[LATCH_LSB +: NUM_KEY] = latch;
    return w;
  endfunction

endpackage

// File: rtl/io_input_cond_debounce_bit.sv
// One input bit: multi-flop synchronizer followed by a saturating-count
// debouncer that only accepts a level held for DEBOUNCE_CYCLES cycles.
module debounce_bit
  import io_input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_d
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic                   d_q;
  logic                   d_d;
  logic                   s;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], i_raw};
  assign s      = sync_q[SYNC_STAGES-1];

  // Any cycle where s agrees with d restarts the count, so a glitch never
  // accumulates towards a transition.
  always_comb begin
    cnt_d = '0;
    d_d   = d_q;
    if (s != d_q) begin
      if (cnt_q == CNT_MAX) begin
        d_d = s;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      d_q    <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      d_q    <= d_d;
    end
  end

  assign o_d = d_q;

endmodule

// File: rtl/io_input_cond.sv
// Conditions raw slide switches and push buttons into a registered IO word:
// per-bit synchronize/debounce, key press pulses and sticky press latches.
module io_input_cond
  import io_input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SW-1:0]  i_sw,
  input  logic [NUM_KEY-1:0] i_key_n,
  input  logic [NUM_KEY-1:0] i_ack,
  output logic [NUM_KEY-1:0] o_key_press,
  output logic [IO_W-1:0]    o_io_sw
);

  logic [NUM_IN-1:0]  raw;
  logic [NUM_IN-1:0]  deb;
  logic [NUM_SW-1:0]  sw_deb;
  logic [NUM_KEY-1:0] key_deb;

  logic [NUM_KEY-1:0] key_prev_q;
  logic [NUM_KEY-1:0] press_q;
  logic [NUM_KEY-1:0] press_d;
  logic [NUM_KEY-1:0] latch_q;
  logic [NUM_KEY-1:0] latch_d;

  // Keys are inverted up front so every bit idles (and resets) at 0.
  assign raw = {~i_key_n, i_sw};

  generate
    for (genvar g = 0; g < NUM_IN; g++) begin : g_bit
      debounce_bit #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .SYNC_STAGES     (SYNC_STAGES)
      ) u_debounce (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_raw   (raw[g]),
        .o_d     (deb[g])
      );
    end
  endgenerate

  assign sw_deb  = deb[NUM_SW-1:0];
  assign key_deb = deb[NUM_SW +: NUM_KEY];

  // Rising edges only; set takes priority over a coincident ack.
  assign press_d = key_deb & ~key_prev_q;
  assign latch_d = (latch_q & ~i_ack) | press_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      key_prev_q <= '0;
      press_q    <= '0;
      latch_q    <= '0;
    end else begin
      key_prev_q <= key_deb;
      press_q    <= press_d;
      latch_q    <= latch_d;
    end
  end

  assign o_key_press = press_q;
  assign o_io_sw     = pack_io(sw_deb, key_deb, latch_q);

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond with a short debounce interval.
module tb_io_input_cond;

  logic        clk;
  logic        rst;
  logic [9:0]  sw;
  logic [3:0]  key_n;
  logic [3:0]  ack;
  logic [3:0]  key_press;
  logic [31:0] io_sw;

  int checks;
  int errors;
  int pulses;

  io_input_cond #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_sw        (sw),
    .i_key_n     (key_n),
    .i_ack       (ack),
    .o_key_press (key_press),
    .o_io_sw     (io_sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, req);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sw     = '0;
    key_n  = 4'hF;
    ack    = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_io", io_sw, 32'h0);
    chk("rst_press", {28'h0, key_press}, 32'h0);
    rst = 1'b0;
    repeat (6) tick();
    chk("idle_io", io_sw, 32'h0);

    // sw[0] held high: appears at edge 6, not edge 5
    sw[0] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("sw0_e5", io_sw, 32'h0);
      if (i == 6) chk("sw0_e6", io_sw, 32'h1);
    end

    // sw[3] bounces 1,0,1 then holds high
    sw[3] = 1'b1; tick(); tick();
    chk("sw3_bounce_a", io_sw, 32'h1);
    sw[3] = 1'b0; tick(); tick();
    chk("sw3_bounce_b", io_sw, 32'h1);
    sw[3] = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) chk("sw3_e5", io_sw, 32'h1);
      if (i == 6) chk("sw3_e6", io_sw, 32'h9);
    end

    // key 1 press: debounced at 6, pulse at 7, latch at 8
    key_n[1] = 1'b0;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (key_press[1]) pulses++;
      if (i == 5) chk("key1_e5", io_sw, 32'h9);
      if (i == 6) chk("key1_e6", io_sw, 32'h809);
      if (i == 7) chk("key1_pulse", {28'h0, key_press}, 32'h2);
      if (i == 8) chk("key1_latch", io_sw, 32'h8809);
    end
    chk("key1_npulse", pulses, 1);

    // key 1 release: key bit clears, latch holds, no pulse
    key_n[1] = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (key_press[1]) pulses++;
      if (i == 6) chk("rel1_e6", io_sw, 32'h8009);
    end
    chk("rel1_npulse", pulses, 0);

    // New press with ack coincident with the pulse: set wins
    key_n[1] = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    chk("key1b_pulse", {28'h0, key_press}, 32'h2);
    ack[1] = 1'b1;
    tick();
    ack = '0;
    chk("ack_vs_set", io_sw, 32'h8809);
    tick();
    chk("ack_vs_set_hold", io_sw, 32'h8809);

    // ack alone clears, ack on clear bits does nothing
    ack[1] = 1'b1; tick(); ack = '0;
    chk("ack_clear", io_sw, 32'h0809);
    ack = 4'hF; tick(); ack = '0;
    chk("ack_noop", io_sw, 32'h0809);

    key_n[1] = 1'b1;
    repeat (8) tick();
    chk("rel1b", io_sw, 32'h0009);

    // Reset mid-count with all switches and key 0 held
    sw    = 10'h3FF;
    key_n = 4'hE;
    repeat (4) tick();
    chk("pre_rst", io_sw, 32'h0009);
    rst = 1'b1;
    tick();
    chk("midrst_io", io_sw, 32'h0);
    chk("midrst_press", {28'h0, key_press}, 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 5) chk("postrst_e5", io_sw, 32'h0);
      if (i == 6) chk("postrst_e6", io_sw, 32'h7FF);
      if (i == 7) chk("postrst_pulse", {28'h0, key_press}, 32'h1);
      if (i == 8) chk("postrst_latch", io_sw, 32'h47FF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
